// File: rtl/uart_cmd_bridge_if.sv
// Handshake bundle between the command bridge, the uart FIFOs
// and the register bus.
interface uart_cmd_bridge_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              rx_empty;
    logic [DATA_W-1:0] r_data;
    logic              rd_uart;
    logic              tx_full;
    logic              wr_uart;
    logic [DATA_W-1:0] w_data;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_we;
    logic              bus_re;
    logic [DATA_W-1:0] bus_rdata;
    logic              busy;
    logic              frame_err;

    modport master (
        input  rx_empty, r_data, tx_full, bus_rdata,
        output rd_uart, wr_uart, w_data, bus_addr, bus_wdata,
        output bus_we, bus_re, busy, frame_err
    );

    modport slave (
        output rx_empty, r_data, tx_full, bus_rdata,
        input  rd_uart, wr_uart, w_data, bus_addr, bus_wdata,
        input  bus_we, bus_re, busy, frame_err
    );
endinterface

// File: rtl/uart_cmd_bridge.sv
// Serial command engine: decodes W/R frames from the rx FIFO,
// runs one register-bus access, answers with one tx byte.
module uart_cmd_bridge #(
    parameter int          ADDR_W      = 8,
    parameter int          DATA_W      = 8,
    parameter int          TIMEOUT_CYC = 100000,
    parameter logic [7:0]  CMD_WR      = 8'h57,
    parameter logic [7:0]  CMD_RD      = 8'h52,
    parameter logic [7:0]  RSP_ACK     = 8'h4B,
    parameter logic [7:0]  RSP_NAK     = 8'h3F
) (
    input  logic                clk,
    input  logic                rst,
    uart_cmd_bridge_if.master   bus
);
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE, GET_ADDR, GET_DATA, BUS_WR, BUS_RD, RD_WAIT, SEND
    } state_t;

    state_t            r_state, w_next;
    logic              r_is_wr, w_is_wr;
    logic [CNT_W-1:0]  r_cnt, w_cnt;
    logic [DATA_W-1:0] r_w_data, w_w_data;
    logic [ADDR_W-1:0] r_addr, w_addr;
    logic [DATA_W-1:0] r_wdata, w_wdata;
    logic              w_rd, w_wr, w_we, w_re, w_ferr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_is_wr  <= 1'b0;
            r_cnt    <= '0;
            r_w_data <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else begin
            r_state  <= w_next;
            r_is_wr  <= w_is_wr;
            r_cnt    <= w_cnt;
            r_w_data <= w_w_data;
            r_addr   <= w_addr;
            r_wdata  <= w_wdata;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_is_wr  = r_is_wr;
        w_cnt    = r_cnt;
        w_w_data = r_w_data;
        w_addr   = r_addr;
        w_wdata  = r_wdata;
        w_rd     = 1'b0;
        w_wr     = 1'b0;
        w_we     = 1'b0;
        w_re     = 1'b0;
        w_ferr   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!bus.rx_empty) begin
                    w_rd  = 1'b1;
                    w_cnt = '0;
                    if (bus.r_data == CMD_WR) begin
                        w_is_wr = 1'b1;
                        w_next  = GET_ADDR;
                    end else if (bus.r_data == CMD_RD) begin
                        w_is_wr = 1'b0;
                        w_next  = GET_ADDR;
                    end else begin
                        w_w_data = RSP_NAK;
                        w_ferr   = 1'b1;
                        w_next   = SEND;
                    end
                end
            end
            GET_ADDR, GET_DATA: begin
                if (!bus.rx_empty) begin
                    w_rd  = 1'b1;
                    w_cnt = '0;
                    if (r_state == GET_ADDR) begin
                        w_addr = bus.r_data[ADDR_W-1:0];
                        w_next = r_is_wr ? GET_DATA : BUS_RD;
                    end else begin
                        w_wdata = bus.r_data;
                        w_next  = BUS_WR;
                    end
                end else if (r_cnt == CNT_MAX) begin
                    // Host went quiet mid-frame: drop it silently
                    w_ferr = 1'b1;
                    w_cnt  = '0;
                    w_next = IDLE;
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            BUS_WR: begin
                w_we     = 1'b1;
                w_w_data = RSP_ACK;
                w_next   = SEND;
            end
            BUS_RD: begin
                w_re   = 1'b1;
                w_next = RD_WAIT;
            end
            RD_WAIT: begin
                w_w_data = bus.bus_rdata;
                w_next   = SEND;
            end
            SEND: begin
                if (!bus.tx_full) begin
                    w_wr   = 1'b1;
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign bus.rd_uart   = w_rd & ~rst;
    assign bus.wr_uart   = w_wr & ~rst;
    assign bus.bus_we    = w_we & ~rst;
    assign bus.bus_re    = w_re & ~rst;
    assign bus.frame_err = w_ferr & ~rst;
    assign bus.busy      = (r_state != IDLE) & ~rst;
    assign bus.w_data    = r_w_data;
    assign bus.bus_addr  = r_addr;
    assign bus.bus_wdata = r_wdata;
endmodule

// File: tb/tb_uart_cmd_bridge.sv
// Directed bench for uart_cmd_bridge: rx FIFO model, bus
// read-data responder and event logs checked per scenario.
module tb_uart_cmd_bridge;
    localparam int TO = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_cmd_bridge_if #(.ADDR_W(8), .DATA_W(8)) bif ();

    uart_cmd_bridge #(
        .ADDR_W(8), .DATA_W(8), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bif.master)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int fails = 0;

    logic [7:0]  rxq[$];
    logic [7:0]  push_log[$];
    logic [15:0] we_log[$];
    logic [7:0]  re_log[$];
    logic [7:0]  rd_val = 8'h00;
    logic        re_prev = 1'b0;
    logic [7:0]  tmp;
    int cyc = 0;
    int n_pop = 0;
    int n_ferr = 0;
    int viol = 0;
    int first_pop = -1;
    int push_cyc = -1;
    int ferr_cyc = -1;

    initial begin
        bif.rx_empty  = 1'b1;
        bif.r_data    = 8'h00;
        bif.tx_full   = 1'b0;
        bif.bus_rdata = 8'hEE;
        forever begin
            @(negedge clk);
            #1;
            bif.rx_empty  = (rxq.size() == 0);
            bif.r_data    = bif.rx_empty ? 8'h00 : rxq[0];
            bif.bus_rdata = re_prev ? rd_val : 8'hEE;
            #1;
            cyc++;
            if (bif.wr_uart && bif.tx_full) viol++;
            if (!rst) begin
                if (bif.rd_uart) begin
                    if (bif.rx_empty) viol++;
                    else begin
                        if (first_pop < 0) first_pop = cyc;
                        n_pop++;
                        tmp = rxq.pop_front();
                    end
                end
                if (bif.wr_uart) begin
                    if (push_cyc < 0) push_cyc = cyc;
                    push_log.push_back(bif.w_data);
                end
                if (bif.bus_we) we_log.push_back({bif.bus_addr, bif.bus_wdata});
                if (bif.bus_re) re_log.push_back(bif.bus_addr);
                if (bif.frame_err) begin
                    if (ferr_cyc < 0) ferr_cyc = cyc;
                    n_ferr++;
                end
            end
            re_prev = bif.bus_re;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1);
    end

    task automatic clear_logs();
        push_log.delete();
        we_log.delete();
        re_log.delete();
        n_pop = 0;
        n_ferr = 0;
        first_pop = -1;
        push_cyc = -1;
        ferr_cyc = -1;
    endtask

    task automatic settle(input int n);
        int k;
        repeat (n) @(negedge clk);
        k = 0;
        #3;
        while (bif.busy && k < 300) begin
            @(negedge clk);
            #3;
            k++;
        end
        tests_run++;
        if (bif.busy !== 1'b0) begin
            fails++;
            $display("FAIL settle: busy=%b after budget, required 0", bif.busy);
        end
    endtask

    task automatic test_reset();
        logic [29:0] outs;
        @(negedge clk);
        rst = 1'b1;
        rxq.push_back(8'h57);
        repeat (2) @(negedge clk);
        #3;
        outs = {bif.rd_uart, bif.wr_uart, bif.bus_we, bif.bus_re,
                bif.busy, bif.frame_err, bif.w_data, bif.bus_addr,
                bif.bus_wdata};
        tests_run++;
        if (outs !== 30'h0) begin
            fails++;
            $display("FAIL reset_outputs: got %h, required 0", outs);
        end
        @(negedge clk);
        rxq.delete();
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic test_write();
        @(negedge clk);
        clear_logs();
        rxq.push_back(8'h57);
        rxq.push_back(8'h10);
        rxq.push_back(8'hA5);
        settle(6);
        tests_run++;
        if (we_log.size() !== 1 || we_log[0] !== 16'h10A5) begin
            fails++;
            $display("FAIL write_bus: n=%0d first=%h, required 1 x 10A5",
                     we_log.size(), we_log[0]);
        end
        tests_run++;
        if (push_log.size() !== 1 || push_log[0] !== 8'h4B) begin
            fails++;
            $display("FAIL write_rsp: n=%0d first=%h, required 1 x 4B",
                     push_log.size(), push_log[0]);
        end
        tests_run++;
        if (push_cyc - first_pop !== 4) begin
            fails++;
            $display("FAIL write_latency: got %0d, required 4",
                     push_cyc - first_pop);
        end
        tests_run++;
        if (re_log.size() !== 0 || n_ferr !== 0) begin
            fails++;
            $display("FAIL write_side: re=%0d ferr=%0d, required 0 0",
                     re_log.size(), n_ferr);
        end
    endtask

    task automatic test_read();
        @(negedge clk);
        clear_logs();
        rd_val = 8'h3C;
        rxq.push_back(8'h52);
        rxq.push_back(8'h22);
        settle(6);
        tests_run++;
        if (re_log.size() !== 1 || re_log[0] !== 8'h22) begin
            fails++;
            $display("FAIL read_bus: n=%0d addr=%h, required 1 x 22",
                     re_log.size(), re_log[0]);
        end
        tests_run++;
        if (push_log.size() !== 1 || push_log[0] !== 8'h3C) begin
            fails++;
            $display("FAIL read_rsp: n=%0d first=%h, required 1 x 3C",
                     push_log.size(), push_log[0]);
        end
        tests_run++;
        if (push_cyc - first_pop !== 4 || we_log.size() !== 0) begin
            fails++;
            $display("FAIL read_latency: lat=%0d we=%0d, required 4 0",
                     push_cyc - first_pop, we_log.size());
        end
    endtask

    task automatic test_nak();
        @(negedge clk);
        clear_logs();
        rxq.push_back(8'h00);
        settle(3);
        tests_run++;
        if (n_ferr !== 1 || ferr_cyc !== first_pop) begin
            fails++;
            $display("FAIL nak_ferr: n=%0d at %0d, required 1 at %0d",
                     n_ferr, ferr_cyc, first_pop);
        end
        tests_run++;
        if (push_log.size() !== 1 || push_log[0] !== 8'h3F) begin
            fails++;
            $display("FAIL nak_rsp: n=%0d first=%h, required 1 x 3F",
                     push_log.size(), push_log[0]);
        end
        tests_run++;
        if (we_log.size() !== 0 || re_log.size() !== 0) begin
            fails++;
            $display("FAIL nak_bus: we=%0d re=%0d, required 0 0",
                     we_log.size(), re_log.size());
        end
    endtask

    task automatic test_timeout();
        @(negedge clk);
        clear_logs();
        rxq.push_back(8'h57);
        rxq.push_back(8'h10);
        settle(TO + 8);
        tests_run++;
        if (n_ferr !== 1 || ferr_cyc - first_pop !== TO + 1) begin
            fails++;
            $display("FAIL timeout_ferr: n=%0d delay=%0d, required 1 %0d",
                     n_ferr, ferr_cyc - first_pop, TO + 1);
        end
        tests_run++;
        if (push_log.size() !== 0 || we_log.size() !== 0) begin
            fails++;
            $display("FAIL timeout_quiet: push=%0d we=%0d, required 0 0",
                     push_log.size(), we_log.size());
        end
        @(negedge clk);
        clear_logs();
        rd_val = 8'h77;
        rxq.push_back(8'h52);
        rxq.push_back(8'h10);
        settle(6);
        tests_run++;
        if (push_log.size() !== 1 || push_log[0] !== 8'h77
            || re_log.size() !== 1 || re_log[0] !== 8'h10) begin
            fails++;
            $display("FAIL timeout_recover: push=%0d %h re=%0d %h, required 1 77 1 10",
                     push_log.size(), push_log[0], re_log.size(), re_log[0]);
        end
    endtask

    task automatic test_tx_full();
        @(negedge clk);
        clear_logs();
        rd_val = 8'h99;
        bif.tx_full = 1'b1;
        rxq.push_back(8'h57);
        rxq.push_back(8'h10);
        rxq.push_back(8'hA5);
        rxq.push_back(8'h52);
        rxq.push_back(8'h33);
        repeat (50) @(negedge clk);
        #3;
        tests_run++;
        if (n_pop !== 3 || push_log.size() !== 0 || bif.busy !== 1'b1) begin
            fails++;
            $display("FAIL txfull_hold: pops=%0d push=%0d busy=%b, required 3 0 1",
                     n_pop, push_log.size(), bif.busy);
        end
        @(negedge clk);
        bif.tx_full = 1'b0;
        settle(8);
        tests_run++;
        if (push_log.size() !== 2 || push_log[0] !== 8'h4B
            || push_log[1] !== 8'h99) begin
            fails++;
            $display("FAIL txfull_release: n=%0d %h %h, required 2 4B 99",
                     push_log.size(), push_log[0], push_log[1]);
        end
    endtask

    task automatic test_reset_mid();
        logic [29:0] outs;
        @(negedge clk);
        clear_logs();
        rxq.push_back(8'h57);
        rxq.push_back(8'h01);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #3;
        outs = {bif.rd_uart, bif.wr_uart, bif.bus_we, bif.bus_re,
                bif.busy, bif.frame_err, bif.w_data, bif.bus_addr,
                bif.bus_wdata};
        tests_run++;
        if (outs !== 30'h0) begin
            fails++;
            $display("FAIL midreset_outputs: got %h, required 0", outs);
        end
        @(negedge clk);
        rst = 1'b0;
        clear_logs();
        rxq.push_back(8'h57);
        rxq.push_back(8'h01);
        rxq.push_back(8'h02);
        settle(6);
        tests_run++;
        if (we_log.size() !== 1 || we_log[0] !== 16'h0102
            || push_log.size() !== 1 || push_log[0] !== 8'h4B) begin
            fails++;
            $display("FAIL midreset_frame: we=%0d %h push=%0d %h, required 1 0102 1 4B",
                     we_log.size(), we_log[0], push_log.size(), push_log[0]);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        clear_logs();
        rd_val = 8'h5A;
        rxq.push_back(8'h57);
        rxq.push_back(8'h0A);
        rxq.push_back(8'h0B);
        rxq.push_back(8'h52);
        rxq.push_back(8'h0A);
        settle(12);
        tests_run++;
        if (we_log.size() !== 1 || we_log[0] !== 16'h0A0B
            || re_log.size() !== 1 || re_log[0] !== 8'h0A) begin
            fails++;
            $display("FAIL b2b_bus: we=%0d %h re=%0d %h, required 1 0A0B 1 0A",
                     we_log.size(), we_log[0], re_log.size(), re_log[0]);
        end
        tests_run++;
        if (push_log.size() !== 2 || push_log[0] !== 8'h4B
            || push_log[1] !== 8'h5A) begin
            fails++;
            $display("FAIL b2b_rsp: n=%0d %h %h, required 2 4B 5A",
                     push_log.size(), push_log[0], push_log[1]);
        end
        tests_run++;
        if (viol !== 0 || bif.busy !== 1'b0) begin
            fails++;
            $display("FAIL protocol: violations=%0d busy=%b, required 0 0",
                     viol, bif.busy);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_nak();
        test_timeout();
        test_tx_full();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
